// File: rtl/y_update_sequencer.sv
// ---------------------------------------------------------------------------
// y_update_sequencer
//
// Walks a change list one entry at a time. For each entry it:
//   1. spends one cycle in FETCH while the change memory returns the entry,
//   2. grants the Y SRAM bus to the update-Y datapath (COMPUTE) until that
//      datapath reports completion,
//   3. grants the Y SRAM bus to the write-back path (WRITE) until the write
//      completes,
//   4. spends one cycle in NEXT to count the entry and choose between the
//      next entry and finishing.
// Each wait in COMPUTE or WRITE is guarded by a watchdog. When the watchdog
// expires the sequencer parks in ERR with a sticky error flag until aborted.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-high reset
//   start_i          one-cycle request to run the list (accepted in IDLE only)
//   abort_i          synchronous cancel back to IDLE from any state
//   num_changes_i    number of list entries, captured on an accepted start
//   compute_done_i   update-Y compute complete (honoured in COMPUTE only)
//   write_done_i     Y write-back complete (honoured in WRITE only)
//   chg_addr_o       change-list read address of the current entry
//   compute_enable_o update-Y datapath enable / Y SRAM bus grant
//   write_enable_o   write-back path enable / Y SRAM bus grant
//   busy_o           high whenever the sequencer is not in IDLE
//   all_done_o       one-cycle pulse when the whole list has completed
//   entry_count_o    entries fully written back since the last accepted start
//   timeout_err_o    sticky watchdog error flag
// ---------------------------------------------------------------------------
module y_update_sequencer #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned AW      = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] num_changes_i,
  input  logic          compute_done_i,
  input  logic          write_done_i,
  output logic [AW-1:0] chg_addr_o,
  output logic          compute_enable_o,
  output logic          write_enable_o,
  output logic          busy_o,
  output logic          all_done_o,
  output logic [AW-1:0] entry_count_o,
  output logic          timeout_err_o
);

  // Watchdog wide enough to hold TIMEOUT itself.
  localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter is 0 in the first cycle of a wait, so the cycle in which it
  // would step to TIMEOUT is the one where it currently holds TIMEOUT-1.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_COMPUTE,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   num_q;
  logic [AW-1:0]   chg_addr_q;
  logic [AW-1:0]   entry_count_q;
  logic [WDW-1:0]  wd_q;
  logic            compute_en_q;
  logic            write_en_q;
  logic            busy_q;
  logic            all_done_q;
  logic            timeout_err_q;

  logic [AW-1:0]   entry_count_d;
  logic            wd_expired;

  // Count the entry leaving NEXT; the finish decision uses this new value.
  assign entry_count_d = entry_count_q + AW'(1);
  assign wd_expired    = (wd_q == WD_LAST);

  // Single registered FSM: every output is a flop loaded together with the
  // next state, so enables and flags line up exactly with the state they
  // describe and never glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      num_q         <= '0;
      chg_addr_q    <= '0;
      entry_count_q <= '0;
      wd_q          <= '0;
      compute_en_q  <= 1'b0;
      write_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // allDone is a pulse; only the transition into DONE raises it.
      all_done_q <= 1'b0;

      if (abort_i) begin
        // Cancel wins over everything. Progress counters are left as they
        // are so software can see how far the run got.
        state_q      <= S_IDLE;
        compute_en_q <= 1'b0;
        write_en_q   <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_i) begin
              busy_q        <= 1'b1;
              entry_count_q <= '0;
              if (num_changes_i != '0) begin
                state_q       <= S_FETCH;
                num_q         <= num_changes_i;
                chg_addr_q    <= '0;
                timeout_err_q <= 1'b0;
              end else begin
                // Empty list: finish straight away without touching the bus.
                state_q    <= S_DONE;
                all_done_q <= 1'b1;
              end
            end
          end

          S_FETCH: begin
            // Change memory data is valid after this cycle; hand the bus to
            // the compute datapath and arm the watchdog.
            state_q      <= S_COMPUTE;
            compute_en_q <= 1'b1;
            wd_q         <= '0;
          end

          S_COMPUTE: begin
            // A done arriving in the watchdog's last cycle still wins.
            if (compute_done_i) begin
              state_q      <= S_WRITE;
              compute_en_q <= 1'b0;
              write_en_q   <= 1'b1;
              wd_q         <= '0;
            end else if (wd_expired) begin
              state_q       <= S_ERR;
              compute_en_q  <= 1'b0;
              timeout_err_q <= 1'b1;
            end else begin
              wd_q <= wd_q + WDW'(1);
            end
          end

          S_WRITE: begin
            if (write_done_i) begin
              state_q    <= S_NEXT;
              write_en_q <= 1'b0;
            end else if (wd_expired) begin
              state_q       <= S_ERR;
              write_en_q    <= 1'b0;
              timeout_err_q <= 1'b1;
            end else begin
              wd_q <= wd_q + WDW'(1);
            end
          end

          S_NEXT: begin
            entry_count_q <= entry_count_d;
            if (entry_count_d == num_q) begin
              state_q    <= S_DONE;
              all_done_q <= 1'b1;
            end else begin
              // Natural AW-bit wrap; unreachable for lists shorter than 2^AW.
              chg_addr_q <= chg_addr_q + AW'(1);
              state_q    <= S_FETCH;
            end
          end

          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end

          S_ERR: begin
            // Parked with the bus released until abort.
            compute_en_q <= 1'b0;
            write_en_q   <= 1'b0;
          end

          default: begin
            state_q      <= S_IDLE;
            compute_en_q <= 1'b0;
            write_en_q   <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chg_addr_o       = chg_addr_q;
  assign compute_enable_o = compute_en_q;
  assign write_enable_o   = write_en_q;
  assign busy_o           = busy_q;
  assign all_done_o       = all_done_q;
  assign entry_count_o    = entry_count_q;
  assign timeout_err_o    = timeout_err_q;

endmodule

// File: tb/tb_y_update_sequencer.sv
// ---------------------------------------------------------------------------
// tb_y_update_sequencer
//
// Drives y_update_sequencer with randomized change lists. A responder process
// answers the enables with done pulses after per-entry delays held in tables;
// the expected run length, enable-cycle totals, address sequence and final
// counters are computed from those tables with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_y_update_sequencer;

  localparam int TO = 8;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] num_changes_i;
  logic          compute_done_i;
  logic          write_done_i;
  logic [AW-1:0] chg_addr_o;
  logic          compute_enable_o;
  logic          write_enable_o;
  logic          busy_o;
  logic          all_done_o;
  logic [AW-1:0] entry_count_o;
  logic          timeout_err_o;

  y_update_sequencer #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .num_changes_i   (num_changes_i),
    .compute_done_i  (compute_done_i),
    .write_done_i    (write_done_i),
    .chg_addr_o      (chg_addr_o),
    .compute_enable_o(compute_enable_o),
    .write_enable_o  (write_enable_o),
    .busy_o          (busy_o),
    .all_done_o      (all_done_o),
    .entry_count_o   (entry_count_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 clk = ~clk;

  // Per-entry response delays: done is raised in enable cycle (delay+1).
  int cdel [0:(1<<AW)-1];
  int wdel [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;
  bit stray_en = 1'b0;

  // Monitor tallies (only ever incremented by the responder process).
  int all_done_cnt = 0;
  int cen_cnt      = 0;
  int wen_cnt      = 0;
  int overlap_cnt  = 0;
  int addr_q[$];

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Main thread drives/samples 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Responder and monitor, operating on the falling edge.
  initial begin : responder
    int c_run;
    int w_run;
    bit prev_cen;
    c_run = 0; w_run = 0; prev_cen = 1'b0;
    compute_done_i = 1'b0;
    write_done_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (compute_enable_o && write_enable_o) overlap_cnt++;
      if (all_done_o) all_done_cnt++;
      if (compute_enable_o) begin
        cen_cnt++;
        if (!prev_cen) addr_q.push_back(int'(chg_addr_o));
        c_run++;
        compute_done_i = (c_run == cdel[chg_addr_o] + 1);
      end else begin
        c_run = 0;
        compute_done_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      prev_cen = compute_enable_o;
      if (write_enable_o) begin
        wen_cnt++;
        w_run++;
        write_done_i = (w_run == wdel[chg_addr_o] + 1);
      end else begin
        w_run = 0;
        write_done_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Run a list of n entries with the current delay tables and check the
  // whole transaction against figures derived from the tables.
  task automatic run_list(input int n, input string tag);
    int exp_cen, exp_wen, exp_busy;
    int ad0, cen0, wen0, ov0, busy_cyc, addr_bad;
    exp_cen = 0; exp_wen = 0;
    for (int i = 0; i < n; i++) begin
      exp_cen += cdel[i] + 1;
      exp_wen += wdel[i] + 1;
    end
    // Per entry: FETCH + COMPUTE + WRITE + NEXT, then one DONE cycle.
    exp_busy = exp_cen + exp_wen + 2 * n + 1;
    ad0 = all_done_cnt; cen0 = cen_cnt; wen0 = wen_cnt; ov0 = overlap_cnt;
    addr_q.delete();
    busy_cyc = 0;
    start_i = 1'b1;
    num_changes_i = AW'(n);
    step();
    start_i = 1'b0;
    num_changes_i = AW'($urandom);
    for (int k = 0; k < 3000; k++) begin
      if (!busy_o) break;
      busy_cyc++;
      if (stray_en) start_i = 1'($urandom_range(0, 1));
      step();
    end
    start_i = 1'b0;
    addr_bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) addr_bad++;
    check_value({tag, "_idle"},     busy_o, 0);
    check_value({tag, "_cycles"},   busy_cyc, exp_busy);
    check_value({tag, "_alldone"},  all_done_cnt - ad0, 1);
    check_value({tag, "_cen_cyc"},  cen_cnt - cen0, exp_cen);
    check_value({tag, "_wen_cyc"},  wen_cnt - wen0, exp_wen);
    check_value({tag, "_overlap"},  overlap_cnt - ov0, 0);
    check_value({tag, "_entries"},  entry_count_o, n);
    check_value({tag, "_lastaddr"}, chg_addr_o, n - 1);
    check_value({tag, "_addr_n"},   addr_q.size(), n);
    check_value({tag, "_addr_seq"}, addr_bad, 0);
    check_value({tag, "_terr"},     timeout_err_o, 0);
    $display("run %s: n=%0d busy_cycles=%0d expected=%0d", tag, n, busy_cyc, exp_busy);
  endtask

  task automatic randomize_tables(input int maxd);
    for (int i = 0; i < 16; i++) begin
      cdel[i] = int'($urandom_range(0, maxd));
      wdel[i] = int'($urandom_range(0, maxd));
    end
  endtask

  initial begin : time_guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int ad0, cen0, wen0, n;
    bit found;
    foreach (cdel[i]) begin cdel[i] = 0; wdel[i] = 0; end
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; num_changes_i = '0;
    step(); step();
    check_value("reset_outputs",
                {chg_addr_o, entry_count_o, compute_enable_o, write_enable_o,
                 busy_o, all_done_o, timeout_err_o}, 0);
    rst_i = 1'b0;
    step();

    // Fixed list: 3 entries, compute done 4 cycles in, write done 2 in.
    for (int i = 0; i < 3; i++) begin cdel[i] = 3; wdel[i] = 1; end
    run_list(3, "fixed3");

    // Empty list: immediate allDone, no bus activity.
    ad0 = all_done_cnt; cen0 = cen_cnt; wen0 = wen_cnt;
    start_i = 1'b1; num_changes_i = '0;
    step();
    start_i = 1'b0;
    check_value("zero_alldone", all_done_o, 1);
    check_value("zero_busy", busy_o, 1);
    step();
    check_value("zero_alldone_drop", all_done_o, 0);
    check_value("zero_idle", busy_o, 0);
    check_value("zero_pulses", all_done_cnt - ad0, 1);
    check_value("zero_no_enables", (cen_cnt - cen0) + (wen_cnt - wen0), 0);
    check_value("zero_entries", entry_count_o, 0);

    // Randomized lists with stray done/start pulses that must be ignored.
    stray_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      randomize_tables(5);
      n = int'($urandom_range(1, 6));
      run_list(n, $sformatf("rand%0d", r));
    end

    // Done arriving in the watchdog's final cycle wins.
    cdel[0] = TO - 1; wdel[0] = TO - 1;
    run_list(1, "wd_edge");

    // Compute never completes: ERR after TO cycles in COMPUTE.
    cdel[0] = TO; wdel[0] = 0;
    cen0 = cen_cnt;
    start_i = 1'b1; num_changes_i = AW'(1);
    step();
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (timeout_err_o) begin found = 1'b1; break; end
      step();
    end
    check_value("tmo_raised", found, 1);
    check_value("tmo_cen_cycles", cen_cnt - cen0, TO);
    check_value("tmo_enables", {compute_enable_o, write_enable_o}, 0);
    for (int k = 0; k < 5; k++) begin
      start_i = 1'($urandom_range(0, 1));
      step();
    end
    start_i = 1'b0;
    check_value("tmo_hold_busy", busy_o, 1);
    check_value("tmo_hold_enables", {compute_enable_o, write_enable_o}, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_value("tmo_abort_idle", busy_o, 0);
    check_value("tmo_sticky", timeout_err_o, 1);
    $display("timeout: err=%0d busy=%0d after abort", timeout_err_o, busy_o);

    // Abort during entry 2's compute keeps the progress counters.
    randomize_tables(4);
    ad0 = all_done_cnt;
    start_i = 1'b1; num_changes_i = AW'(4);
    step();
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (compute_enable_o && chg_addr_o == 2) begin found = 1'b1; break; end
      step();
    end
    check_value("abort_reached", found, 1);
    check_value("abort_cleared_err", timeout_err_o, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_value("abort_idle", busy_o, 0);
    check_value("abort_enables", {compute_enable_o, write_enable_o}, 0);
    check_value("abort_addr_kept", chg_addr_o, 2);
    check_value("abort_count_kept", entry_count_o, 2);
    step();
    check_value("abort_no_alldone", all_done_cnt - ad0, 0);
    $display("abort: addr=%0d entries=%0d", chg_addr_o, entry_count_o);

    // Asynchronous reset while writing back entry 2.
    randomize_tables(4);
    start_i = 1'b1; num_changes_i = AW'(3);
    step();
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (write_enable_o && chg_addr_o == 1) begin found = 1'b1; break; end
      step();
    end
    check_value("rst_reached_write", found, 1);
    rst_i = 1'b1;
    #1;
    check_value("rst_async_outputs",
                {chg_addr_o, entry_count_o, compute_enable_o, write_enable_o,
                 busy_o, all_done_o, timeout_err_o}, 0);
    step();
    rst_i = 1'b0;
    step();
    run_list(1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
